encode42_rr: RTL

ENCODE42_RR -- requirements
Module: encode42_rr

---
 rtl/encode42_pkg.sv | 26 ++
 rtl/encode42_rr_prio_rot4.sv | 44 ++++
 rtl/encode42_rr.sv | 115 +++++++++++
 3 files changed

// File: rtl/encode42_pkg.sv
// encode42_pkg -- constants and small helpers shared by the 4-to-2 encoder.
//   IDX_W  : width of an encoded source index
//   REQ_N  : number of request sources
//   FIXED/RR : values of the RR_MODE parameter of encode42_rr
package encode42_pkg;

  localparam int IDX_W = 2;
  localparam int REQ_N = 4;

  // Priority mode selector values for RR_MODE.
  localparam int FIXED = 0;
  localparam int RR    = 1;

  // Result of one priority search.
  typedef struct packed {
    logic             any;
    logic             multi;
    logic [IDX_W-1:0] idx;
  } sel_t;

  // Index following idx, wrapping from REQ_N-1 back to 0.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/encode42_rr_prio_rot4.sv
// prio_rot4 -- combinational rotated priority search over 4 request bits.
//   req   [3:0] in  : request bits, one per source index
//   start [1:0] in  : index where the search begins (searched upward, mod 4)
//   idx   [1:0] out : first set index at or after start
//   any         out : at least one request bit is set
//   multi       out : two or more request bits are set
module prio_rot4
  import encode42_pkg::*;
(
  input  logic [REQ_N-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             multi
);

  logic [REQ_N-1:0] rot;
  logic [IDX_W-1:0] off;
  logic             found;

  always_comb begin
    rot   = '0;
    off   = '0;
    found = 1'b0;
    // rot[i] is the request at position start+i, so a plain
    // lowest-set-bit search over rot gives the offset from start.
    for (int i = 0; i < REQ_N; i++) begin
      rot[i] = req[IDX_W'(start + IDX_W'(i))];
    end
    for (int i = 0; i < REQ_N; i++) begin
      if (rot[i] && !found) begin
        off   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

  // Offset is added back modulo 4 by the 2-bit wrap.
  assign idx   = start + off;
  assign any   = |req;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(req & (req - REQ_N'(1)));

endmodule

// File: rtl/encode42_rr.sv
// encode42_rr -- registered 4-to-2 priority encoder with round-robin or
// fixed priority, valid/ready on both sides and a saturating count of
// accepted all-zero words.
//   Parameters: RR_MODE (RR = rotating priority, FIXED = lowest index wins),
//               CNT_W (width of zero_cnt)
//   clk, rst        : clock, synchronous active-high reset
//   en              : enable; low stops new input being accepted
//   in, in_valid    : request word and its valid strobe
//   in_ready        : word is accepted this cycle when in_valid is also high
//   out, multi      : selected index and "more than one bit set" flag
//   out_valid       : out/multi hold a result
//   out_ready       : consumer takes the result this cycle
//   zero_cnt        : saturating count of accepted all-zero words
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds its data stable while valid is high and
// ready is low; ready never depends on the same side's valid.
module encode42_rr
  import encode42_pkg::*;
#(
  parameter int RR_MODE = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [REQ_N-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out,
  output logic             multi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] zero_cnt
);

  logic [IDX_W-1:0] out_q, out_d;
  logic             multi_q, multi_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             consume;
  logic [IDX_W-1:0] start;
  sel_t             sel;

  // The output slot is free when empty or being drained this cycle,
  // which lets a new result replace the old one without a bubble.
  assign in_ready = en & (~valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign consume  = valid_q & out_ready;

  // Fixed priority is a search that always starts at index 0.
  assign start = (RR_MODE == RR) ? next_idx(ptr_q) : '0;

  prio_rot4 u_prio (
    .req   (in),
    .start (start),
    .idx   (sel.idx),
    .any   (sel.any),
    .multi (sel.multi)
  );

  always_comb begin
    out_d   = out_q;
    multi_d = multi_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (accept) begin
      if (sel.any) begin
        out_d   = sel.idx;
        multi_d = sel.multi;
        valid_d = 1'b1;
        if (RR_MODE == RR) begin
          ptr_d = sel.idx;
        end
      end else begin
        // An all-zero word yields no result; it only counts.
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (consume) begin
          valid_d = 1'b0;
        end
      end
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      multi_q <= 1'b0;
      valid_q <= 1'b0;
      // ptr=3 makes the first rotating search begin at index 0.
      ptr_q   <= IDX_W'(REQ_N - 1);
      cnt_q   <= '0;
    end else begin
      out_q   <= out_d;
      multi_q <= multi_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out       = out_q;
  assign multi     = multi_q;
  assign out_valid = valid_q;
  assign zero_cnt  = cnt_q;

endmodule
